// File: rtl/array_feeder_pkg.sv
// array_feeder_pkg: shared constants for the systolic array feeder
package array_feeder_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ROWS = 3;
  localparam int DEF_COLS = 4;
  localparam logic CTL_MAC = 1'b0;
  localparam logic CTL_SHIFT = 1'b1;
  function automatic int drain_latency(input int rows, input int cols);
    return 2 * rows + cols + 1;
  endfunction
endpackage

// File: rtl/array_feeder_skew_line.sv
// skew_line: fixed-depth register chain with async active-low clear
module skew_line #(
  parameter int depth = 1,
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  logic [width-1:0] sr [depth];
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < depth; i++) sr[i] <= '0;
    else begin
      sr[0] <= d;
      for (int i = 1; i < depth; i++) sr[i] <= sr[i-1];
    end
  assign q = sr[depth-1];
endmodule

// File: rtl/array_feeder.sv
// array_feeder: skews K-step beats into a rows x cols systolic array and sequences the drain
module array_feeder
  import array_feeder_pkg::*;
#(
  parameter int width = DEF_WIDTH,
  parameter int rows = DEF_ROWS,
  parameter int cols = DEF_COLS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_last,
  input  logic [cols*width-1:0] s_in,
  input  logic [rows*width-1:0] s_w,
  output logic [cols*width-1:0] ins,
  output logic [rows*width-1:0] ws,
  output logic [rows*cols-1:0]  ctls,
  output logic [cols-1:0]       out_valid,
  output logic                  busy,
  output logic                  done
);
  localparam int LAT = drain_latency(rows, cols);
  localparam int CW = $clog2(2 * rows + cols + 2);
  localparam logic [1:0] IDLE = 2'd0, FEED = 2'd1, FLUSH = 2'd2, DRAIN = 2'd3;
  logic [1:0] state;
  logic armed, accept, draining;
  logic [CW-1:0] cnt, el;
  logic [cols*width-1:0] in_d;
  logic [rows*width-1:0] w_d;
  logic [cols-1:0] shift_col;
  assign s_ready = armed && (state == IDLE || state == FEED);
  assign accept = s_valid && s_ready;
  assign draining = state == FLUSH || state == DRAIN;
  // el counts cycles since the last accepted beat (1 on the cycle after it)
  assign el = CW'(LAT) - cnt;
  assign busy = state != IDLE;
  assign done = state == DRAIN && cnt == '0;
  assign in_d = accept ? s_in : '0;
  assign w_d = accept ? s_w : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      armed <= 1'b0;
      cnt <= '0;
    end else begin
      armed <= 1'b1;
      if (accept && s_last) begin
        state <= FLUSH;
        cnt <= CW'(LAT - 1);
      end else if (accept) state <= FEED;
      else if (state == FLUSH) begin
        cnt <= cnt - 1'b1;
        if (el == CW'(rows + cols - 1)) state <= DRAIN;
      end else if (state == DRAIN) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) state <= IDLE;
      end
    end
  genvar c, r;
  generate
    for (c = 0; c < cols; c++) begin : g_col
      skew_line #(.depth(c + 1), .width(width)) u_skew (
        .clk(clk), .rst(rst), .d(in_d[c*width+:width]), .q(ins[c*width+:width])
      );
      assign shift_col[c] = draining && el >= CW'(rows + c + 1) && el <= CW'(2 * rows + c);
      assign out_valid[c] = draining && el >= CW'(rows + c + 2) && el <= CW'(2 * rows + c + 1);
      for (r = 0; r < rows; r++) begin : g_pe
        assign ctls[r*cols+c] = shift_col[c] ? CTL_SHIFT : CTL_MAC;
      end
    end
    for (r = 0; r < rows; r++) begin : g_row
      skew_line #(.depth(r + 1), .width(width)) u_skew (
        .clk(clk), .rst(rst), .d(w_d[r*width+:width]), .q(ws[r*width+:width])
      );
    end
  endgenerate
endmodule

// File: tb/tb_array_feeder.sv
// tb_array_feeder: directed checks of skew, drain windows, handshake and reset
module tb_array_feeder;
  localparam int W = 8, R = 3, C = 4;
  logic clk = 1'b0, rst, s_valid = 1'b0, s_last = 1'b0;
  logic [C*W-1:0] s_in = '0;
  logic [R*W-1:0] s_w = '0;
  logic s_ready, busy, done;
  logic [C*W-1:0] ins;
  logic [R*W-1:0] ws;
  logic [R*C-1:0] ctls;
  logic [C-1:0] out_valid;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  array_feeder #(.width(W), .rows(R), .cols(C)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_in(s_in), .s_w(s_w), .ins(ins), .ws(ws), .ctls(ctls),
    .out_valid(out_valid), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [R*C-1:0] ctl_exp(input int t);
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) ctl_exp[r*C+c] = t >= R + c + 1 && t <= 2 * R + c;
  endfunction
  function automatic logic [C-1:0] ov_exp(input int t);
    for (int c = 0; c < C; c++) ov_exp[c] = t >= R + c + 2 && t <= 2 * R + c + 1;
  endfunction
  task automatic wait_ready;
    int i = 0;
    while (!s_ready && i < 30) begin
      step;
      i++;
    end
    chk("ready_wait", s_ready, 1'b1);
  endtask
  task automatic beat(input logic last, input logic [7:0] v);
    s_valid = 1'b1;
    s_last = last;
    s_in = {C{v}};
    s_w = {R{v}};
    step;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_in = '1;
    s_w = '1;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_ins"}, ins, 0);
    chk({tag, "_ws"}, ws, 0);
    chk({tag, "_ctls"}, ctls, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, s_ready, 0);
  endtask
  // entered on cycle L+1, leaves on cycle L+12
  task automatic drain_check(input logic data, input logic [7:0] v);
    for (int t = 1; t <= 12; t++) begin
      chk($sformatf("ctls_t%0d", t), ctls, ctl_exp(t));
      chk($sformatf("ov_t%0d", t), out_valid, ov_exp(t));
      chk($sformatf("done_t%0d", t), done, t == 11);
      chk($sformatf("busy_t%0d", t), busy, t <= 11);
      chk($sformatf("ready_t%0d", t), s_ready, t == 12);
      if (data) begin
        chk($sformatf("ins0_t%0d", t), ins[0+:W], t == 1 ? v : 8'h0);
        chk($sformatf("ins3_t%0d", t), ins[3*W+:W], t == 4 ? v : 8'h0);
        chk($sformatf("ws2_t%0d", t), ws[2*W+:W], t == 3 ? v : 8'h0);
      end
      if (t < 12) step;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    #1 rst = 1'b0;
    step;
    step;
    check_zero("reset");
    #2 rst = 1'b1;
    #1 chk("rel_ready", s_ready, 0);
    step;
    chk("arm_ready", s_ready, 1);
    chk("arm_busy", busy, 0);
    // one-beat stream
    wait_ready;
    beat(1'b1, 8'h10);
    drain_check(1'b1, 8'h10);
    // four back-to-back beats
    wait_ready;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("b4_ready%0d", i), s_ready, 1);
      s_valid = 1'b1;
      s_last = i == 4;
      s_in = {C{8'(i * 17)}};
      s_w = {R{8'(i * 17)}};
      step;
      chk($sformatf("b4_ins0_%0d", i), ins[0+:W], 8'(i * 17));
      if (i == 3) chk("b4_ws2", ws[2*W+:W], 8'h11);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("b4_ins3", ins[3*W+:W], 8'h11);
    chk("b4_ins1", ins[1*W+:W], 8'h33);
    drain_check(1'b0, 8'h0);
    // bubble between beats
    wait_ready;
    beat(1'b0, 8'hA5);
    chk("bub_ins0_a", ins[0+:W], 8'hA5);
    chk("bub_ws0_a", ws[0+:W], 8'hA5);
    step;
    chk("bub_ins0_z", ins[0+:W], 8'h00);
    chk("bub_ws0_z", ws[0+:W], 8'h00);
    beat(1'b1, 8'h5A);
    chk("bub_ins0_b", ins[0+:W], 8'h5A);
    chk("bub_ins1", ins[1*W+:W], 8'h00);
    chk("bub_ins2", ins[2*W+:W], 8'hA5);
    chk("bub_ws1", ws[1*W+:W], 8'h00);
    drain_check(1'b0, 8'h0);
    // back-to-back streams with s_valid held high
    wait_ready;
    s_valid = 1'b1;
    s_last = 1'b1;
    s_in = {C{8'h33}};
    s_w = {R{8'h33}};
    step;
    s_in = {C{8'h44}};
    s_w = {R{8'h44}};
    for (int t = 1; t <= 11; t++) begin
      chk($sformatf("bb_ready_t%0d", t), s_ready, 0);
      chk($sformatf("bb_ctls_t%0d", t), ctls, ctl_exp(t));
      step;
    end
    chk("bb_ready_idle", s_ready, 1);
    chk("bb_ctls_idle", ctls, 0);
    chk("bb_done_idle", done, 0);
    step;
    s_valid = 1'b0;
    s_last = 1'b0;
    chk("bb_ins0_2nd", ins[0+:W], 8'h44);
    chk("bb_ws0_2nd", ws[0+:W], 8'h44);
    drain_check(1'b0, 8'h0);
    // reset in the middle of FEED
    wait_ready;
    beat(1'b0, 8'h77);
    chk("mid_busy", busy, 1);
    chk("mid_ins0", ins[0+:W], 8'h77);
    #2 rst = 1'b0;
    #1 check_zero("mid_rst");
    #1 rst = 1'b1;
    #1 chk("mid_rel_ready", s_ready, 0);
    step;
    chk("mid_arm_ready", s_ready, 1);
    chk("mid_arm_busy", busy, 0);
    chk("mid_arm_ins", ins, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
